// File: rtl/mdio_slave_regs.sv
// mdio_slave_regs: Clause-22 MDIO responder (PHY side) with a small 16-bit
// register file. MDC/MDIO are oversampled in the clk domain; bits are sampled
// on synchronized MDC rising edges and MDIO is driven on MDC falling edges.
// Register 0 is a read-only ID; registers 1..NUM_REGS-1 are read/write.
// Optional build macro: MDIO_SLAVE_PREAMBLE_SUPPRESS_EN -- after a completed
// frame addressed to PHY_ADDR the next frame may start without preamble.
module mdio_slave_regs #(
  parameter logic [4:0]  PHY_ADDR     = 5'h01,
  parameter int          NUM_REGS     = 8,
  parameter logic [15:0] ID_VALUE     = 16'h1234,
  parameter int          MIN_PREAMBLE = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic        reg_wr_valid,
  output logic [4:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data,
  output logic        busy
);

  localparam int            PW       = $clog2(MIN_PREAMBLE + 1);
  localparam logic [PW-1:0] PRE_FULL = PW'(MIN_PREAMBLE);

  typedef enum logic [2:0] {
    S_PRE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_DATA
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    bit_q, bit_d;

  logic mdc_meta_q, mdc_sync_q, mdc_prev_q;
  logic mdio_meta_q, mdio_sync_q;
  logic mdc_rise, mdc_fall, bit_in;

  logic [14:0] shift_q;
  logic        is_rd_q, match_q;
  logic [4:0]  regad_q;
  logic [15:0] regs_q [1:NUM_REGS-1];
  logic        wr_valid_q;
  logic [4:0]  wr_addr_q;
  logic [15:0] wr_data_q;

  logic        rd_act_q;
  logic [4:0]  drv_q;
  logic [15:0] rd_sh_q;
  logic        mdio_o_q, mdio_oe_q;

  logic        frame_end, last_regad, wr_fire, addr_mapped;
  logic [15:0] wr_word, rd_word;

  // Two-flop synchronizers for MDC/MDIO plus one MDC history flop for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_meta_q  <= 1'b0;
      mdc_sync_q  <= 1'b0;
      mdc_prev_q  <= 1'b0;
      mdio_meta_q <= 1'b0;
      mdio_sync_q <= 1'b0;
    end else begin
      mdc_meta_q  <= mdc;
      mdc_sync_q  <= mdc_meta_q;
      mdc_prev_q  <= mdc_sync_q;
      mdio_meta_q <= mdio_i;
      mdio_sync_q <= mdio_meta_q;
    end
  end

  assign mdc_rise = mdc_sync_q & ~mdc_prev_q;
  assign mdc_fall = ~mdc_sync_q & mdc_prev_q;
  // MDIO has the same synchronizer depth as MDC, so it is aligned to mdc_rise
  assign bit_in   = mdio_sync_q;

  assign frame_end  = mdc_rise && (state_q == S_DATA) && (bit_q == 4'd15);
  assign last_regad = mdc_rise && (state_q == S_REG) && (bit_q == 4'd4);
  assign wr_word    = {shift_q, bit_in};
  assign wr_fire    = frame_end && !is_rd_q && match_q && addr_mapped &&
                      (regad_q != 5'd0);

  // Frame FSM state, bit counter and preamble counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PRE;
      pre_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      bit_q   <= bit_d;
    end
  end

  // Field sequencing: each field advances only on a sampled MDC rising edge
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    bit_d   = bit_q;
    if (mdc_rise) begin
      case (state_q)
        S_PRE: begin
          if (bit_in) begin
            if (pre_q != PRE_FULL) pre_d = pre_q + 1'b1;
          end else if (pre_q == PRE_FULL) begin
            state_d = S_ST;
            pre_d   = '0;
          end else begin
            pre_d = '0;
          end
        end
        S_ST: begin
          if (bit_in) begin
            state_d = S_OP;
            bit_d   = '0;
          end else begin
            state_d = S_PRE;
          end
        end
        S_OP: begin
          if (bit_q == 4'd0) begin
            bit_d = 4'd1;
          end else if (shift_q[0] != bit_in) begin
            state_d = S_PHY;
            bit_d   = '0;
          end else begin
            state_d = S_PRE;
          end
        end
        S_PHY: begin
          if (bit_q == 4'd4) begin
            state_d = S_REG;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        S_REG: begin
          if (bit_q == 4'd4) begin
            state_d = S_TA;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        S_TA: begin
          if (bit_q == 4'd1) begin
            state_d = S_DATA;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_q == 4'd15) begin
            state_d = S_PRE;
            pre_d   = '0;
`ifdef MDIO_SLAVE_PREAMBLE_SUPPRESS_EN
            if (match_q) pre_d = PRE_FULL;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        default: state_d = S_PRE;
      endcase
    end
  end

  // Register-file lookup; also tells whether an address is mapped for writes
  always_comb begin
    rd_word     = '0;
    addr_mapped = 1'b0;
    if (regad_q == 5'd0) begin
      rd_word     = ID_VALUE;
      addr_mapped = 1'b1;
    end
    for (int i = 1; i < NUM_REGS; i++) begin
      if (regad_q == i[4:0]) begin
        rd_word     = regs_q[i];
        addr_mapped = 1'b1;
      end
    end
  end

  // Shift in frame bits, latch OP/PHYAD/REGAD, commit writes and flag them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      is_rd_q    <= 1'b0;
      match_q    <= 1'b0;
      regad_q    <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wr_valid_q <= 1'b0;
      if (mdc_rise) begin
        shift_q <= {shift_q[13:0], bit_in};
        if (state_q == S_OP && bit_q == 4'd1) is_rd_q <= shift_q[0] & ~bit_in;
        if (state_q == S_PHY && bit_q == 4'd4)
          match_q <= ({shift_q[3:0], bit_in} == PHY_ADDR);
        if (last_regad) regad_q <= {shift_q[3:0], bit_in};
      end
      if (wr_fire) begin
        for (int i = 1; i < NUM_REGS; i++) begin
          if (regad_q == i[4:0]) regs_q[i] <= wr_word;
        end
        wr_valid_q <= 1'b1;
        wr_addr_q  <= regad_q;
        wr_data_q  <= wr_word;
      end
    end
  end

  // Read drive sequence on MDC falls: TA Z, TA 0 (load data), D15..D0, release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_act_q  <= 1'b0;
      drv_q     <= '0;
      rd_sh_q   <= '0;
      mdio_o_q  <= 1'b0;
      mdio_oe_q <= 1'b0;
    end else if (last_regad && is_rd_q && match_q) begin
      rd_act_q <= 1'b1;
      drv_q    <= '0;
    end else if (mdc_fall && rd_act_q) begin
      drv_q <= drv_q + 1'b1;
      if (drv_q == 5'd1) begin
        mdio_oe_q <= 1'b1;
        mdio_o_q  <= 1'b0;
        rd_sh_q   <= rd_word;
      end else if (drv_q >= 5'd2 && drv_q <= 5'd17) begin
        mdio_o_q <= rd_sh_q[15];
        rd_sh_q  <= {rd_sh_q[14:0], 1'b0};
      end else if (drv_q == 5'd18) begin
        mdio_oe_q <= 1'b0;
        mdio_o_q  <= 1'b0;
        rd_act_q  <= 1'b0;
      end
    end
  end

  assign mdio_o       = mdio_o_q;
  assign mdio_oe      = mdio_oe_q;
  assign reg_wr_valid = wr_valid_q;
  assign reg_wr_addr  = wr_addr_q;
  assign reg_wr_data  = wr_data_q;
  assign busy         = (state_q != S_PRE);

endmodule
